csa_accum_ctrl: RTL

//  Sequencer that accumulates a frame of up to N_OPS unsigned operands through one shared

---
 rtl/csa_accum_ctrl_pkg.sv | 18 +
 rtl/carry_save_adder.sv | 17 +
 rtl/csa_accum_dp.sv | 62 ++++++
 rtl/ripple_carry_adder.sv | 26 ++
 rtl/csa_accum_ctrl.sv | 81 ++++++++
 5 files changed

// File: rtl/csa_accum_ctrl_pkg.sv
// Shared definitions for the carry-save frame accumulator.
// Holds the FSM state encodings and a ceiling-log2 helper that is used
// to size the accumulator and the operand counter.
package csa_accum_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_OUT     = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/carry_save_adder.sv
// Library carry-save adder: compresses three W-bit words into a sum word
// and a carry word. The carry word carries weight 2^(i+1) at bit i.
// Ports: a, b, c (addends); sum (bitwise XOR); carry (bitwise majority).
module carry_save_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_dp.sv
// Datapath for the frame accumulator: S/C carry-save registers, one shared
// carry-save adder and one ripple-carry adder that resolves the total.
// Ports: clk, rst_n (async active-low); clear (zero S/C); load (absorb
//   op_data into S/C); resolve (capture S + (C<<1) into sum_data);
//   op_data (W-bit operand); sum_data (SW-bit resolved sum).
module csa_accum_dp #(
  parameter int W  = 4,
  parameter int SW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic          resolve,
  input  logic [W-1:0]  op_data,
  output logic [SW-1:0] sum_data
);

  logic [SW-1:0] s_q, c_q;
  logic [SW-1:0] c_sh, op_ext;
  logic [SW-1:0] csa_sum, csa_carry, rca_sum;
  logic          rca_cout_unused;

  // C bit i has weight 2^(i+1); dropping the top bit on the shift is safe
  // because a full frame total always fits in SW bits.
  assign c_sh   = c_q << 1;
  assign op_ext = {{(SW-W){1'b0}}, op_data};

  carry_save_adder #(.W(SW)) u_csa (
    .a     (s_q),
    .b     (c_sh),
    .c     (op_ext),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  ripple_carry_adder #(.W(SW)) u_rca (
    .a    (s_q),
    .b    (c_sh),
    .cin  (1'b0),
    .sum  (rca_sum),
    .cout (rca_cout_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= '0;
      c_q      <= '0;
      sum_data <= '0;
    end else begin
      if (clear) begin
        s_q <= '0;
        c_q <= '0;
      end else if (load) begin
        s_q <= csa_sum;
        c_q <= csa_carry;
      end
      if (resolve) sum_data <= rca_sum;
    end
  end

endmodule

// File: rtl/ripple_carry_adder.sv
// Library ripple-carry adder: W-bit a + b + cin.
// Ports: a, b (addends); cin (carry in); sum (W-bit result); cout (carry out).
module ripple_carry_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Carry kept in a block-local variable so the chain is a single
  // combinational evaluation rather than a self-referencing vector.
  always_comb begin
    logic cy;
    cy  = cin;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/csa_accum_ctrl.sv
// Frame accumulator sequencer. Operands are absorbed one per accepted beat
// into a carry-save running total; at frame close the total is resolved
// with a single carry-propagate add and held until the consumer takes it.
// Ports: clk, rst_n (async active-low); op_valid/op_data/op_last/op_ready
//   (operand stream); sum_valid/sum_data/sum_err/sum_ready (result
//   handshake; sum_err flags a frame closed at N_OPS without op_last);
//   busy (not idle).
module csa_accum_ctrl
  import csa_accum_ctrl_pkg::*;
#(
  parameter int W     = 4,
  parameter int N_OPS = 8,
  parameter int SW    = W + clog2(N_OPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  input  logic [W-1:0]  op_data,
  input  logic          op_last,
  output logic          op_ready,
  output logic          sum_valid,
  output logic [SW-1:0] sum_data,
  output logic          sum_err,
  input  logic          sum_ready,
  output logic          busy
);

  localparam int CNT_W = clog2(N_OPS) + 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             accept, closing, take;

  assign op_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
  assign sum_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);
  assign accept    = op_valid && op_ready;
  assign take      = sum_valid && sum_ready;
  // count is 0 in IDLE, so the auto-close test is uniform across IDLE/ACCUM.
  assign closing   = op_last || (count == CNT_W'(N_OPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      sum_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            count <= count + 1'b1;
            if (closing) begin
              state   <= ST_RESOLVE;
              sum_err <= ~op_last;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_RESOLVE: state <= ST_OUT;
        default: begin
          if (sum_ready) begin
            state <= ST_IDLE;
            count <= '0;
          end
        end
      endcase
    end
  end

  csa_accum_dp #(.W(W), .SW(SW)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (take),
    .load     (accept),
    .resolve  (state == ST_RESOLVE),
    .op_data  (op_data),
    .sum_data (sum_data)
  );

endmodule
